// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Logic/add/sub/shift ops finish in one cycle;
// unsigned MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
module alu_mc #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c_in,
    output logic [DATA_W-1:0] out,
    output logic [DATA_W-1:0] out_hi,
    output logic              done,
    output logic              P,
    output logic              Z,
    output logic              S,
    output logic              C,
    output logic              OV
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_ADDC = 4'h8;
    localparam logic [3:0] OP_SUBC = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_DIV  = 4'hD;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Control
    logic [CNT_W-1:0] cnt_p0;
    logic             fire_single;
    logic             fire_mc;
    logic             last_step;
    logic             vld_p1;

    // Iterative datapath: hi holds partial product / remainder,
    // lo holds multiplier / dividend shifting into quotient.
    logic              is_div_p0;
    logic              dz_p0;
    logic [DATA_W-1:0] opb_p0;
    logic [DATA_W-1:0] hi_p0;
    logic [DATA_W-1:0] lo_p0;
    logic [DATA_W-1:0] hi_nxt;
    logic [DATA_W-1:0] lo_nxt;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W-1:0] div_trial;
    logic              mc_c;
    logic              mc_ov;

    // Single-cycle datapath
    logic signed [DATA_W-1:0] add_b;
    logic                     add_ci;
    logic                     sub_bi;
    logic [DATA_W:0]          add_ext;
    logic [DATA_W:0]          sub_ext;
    logic [DATA_W-1:0]        alu_res;
    logic                     alu_c;
    logic                     alu_ov;

    // Result selected for the output registers
    logic [DATA_W-1:0] res_lo;
    logic [DATA_W-1:0] res_hi;
    logic              res_c;
    logic              res_ov;

    function automatic logic parity_even(input logic [DATA_W-1:0] v);
        return ~^v;
    endfunction

    // Two's-complement overflow of x + y = r: same-signed operands, result sign flipped.
    function automatic logic ovf_add(input logic signed [DATA_W-1:0] x,
                                     input logic signed [DATA_W-1:0] y,
                                     input logic signed [DATA_W-1:0] r);
        return (x[DATA_W-1] == y[DATA_W-1]) && (r[DATA_W-1] != x[DATA_W-1]);
    endfunction

    // Two's-complement overflow of x - y = r: differently-signed operands, result sign unlike x.
    function automatic logic ovf_sub(input logic signed [DATA_W-1:0] x,
                                     input logic signed [DATA_W-1:0] y,
                                     input logic signed [DATA_W-1:0] r);
        return (x[DATA_W-1] != y[DATA_W-1]) && (r[DATA_W-1] != x[DATA_W-1]);
    endfunction

    assign done = vld_p1;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, accept strobes and ready
    always_comb begin
        state_d     = state_q;
        fire_single = 1'b0;
        fire_mc     = 1'b0;
        last_step   = 1'b0;
        ready       = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (alu_op == OP_MUL || alu_op == OP_DIV) begin
                        fire_mc = 1'b1;
                        state_d = RUN;
                    end else begin
                        fire_single = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt_p0 == CNT_W'(1)) begin
                    last_step = 1'b1;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    // Iteration counter: loaded with DATA_W on accept, counts down once per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (fire_mc) begin
            cnt_p0 <= CNT_W'(DATA_W);
        end else if (state_q == RUN) begin
            cnt_p0 <= cnt_p0 - CNT_W'(1);
        end
    end

    // Operand latch and per-step update of the MUL/DIV working registers
    always_ff @(posedge clk) begin
        if (fire_mc) begin
            is_div_p0 <= (alu_op == OP_DIV);
            dz_p0     <= (b == '0);
            opb_p0    <= b;
            hi_p0     <= '0;
            lo_p0     <= a;
        end else if (state_q == RUN) begin
            hi_p0 <= hi_nxt;
            lo_p0 <= lo_nxt;
        end
    end

    assign mul_sum   = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, opb_p0} : {(DATA_W+1){1'b0}});
    assign div_shift = {hi_p0, lo_p0[DATA_W-1]};
    // Only used when div_shift >= divisor, in which case the difference fits DATA_W bits.
    assign div_trial = div_shift[DATA_W-1:0] - opb_p0;

    // One MUL shift-add or DIV restoring-subtract step. With a zero divisor every
    // trial succeeds, which naturally yields quotient all ones and remainder = a.
    always_comb begin
        hi_nxt = hi_p0;
        lo_nxt = lo_p0;
        if (is_div_p0) begin
            if (div_shift >= {1'b0, opb_p0}) begin
                hi_nxt = div_trial;
                lo_nxt = {lo_p0[DATA_W-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift[DATA_W-1:0];
                lo_nxt = {lo_p0[DATA_W-2:0], 1'b0};
            end
        end else begin
            hi_nxt = mul_sum[DATA_W:1];
            lo_nxt = {mul_sum[0], lo_p0[DATA_W-1:1]};
        end
    end

    assign mc_c  = is_div_p0 ? 1'b0 : (hi_nxt != '0);
    assign mc_ov = is_div_p0 ? dz_p0 : mc_c;

    assign add_b   = (alu_op == OP_INC) ? DATA_W'(1) : b;
    assign add_ci  = (alu_op == OP_ADDC) && c_in;
    assign sub_bi  = (alu_op == OP_SUBC) && c_in;
    assign add_ext = {1'b0, a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_ci};
    assign sub_ext = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, sub_bi};

    // Single-cycle operation result, carry/borrow and signed overflow
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_ov  = 1'b0;
        case (alu_op)
            OP_LD:   alu_res = b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_ADD, OP_ADDC, OP_INC: begin
                alu_res = add_ext[DATA_W-1:0];
                alu_c   = add_ext[DATA_W];
                alu_ov  = ovf_add(a, add_b, add_ext[DATA_W-1:0]);
            end
            OP_SUB, OP_SUBC: begin
                alu_res = sub_ext[DATA_W-1:0];
                alu_c   = sub_ext[DATA_W];
                alu_ov  = ovf_sub(a, b, sub_ext[DATA_W-1:0]);
            end
            OP_SHL: begin
                alu_res = {a[DATA_W-2:0], 1'b0};
                alu_c   = a[DATA_W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a[DATA_W-1:1]};
                alu_c   = a[0];
            end
            default: begin
                alu_res = '0;
            end
        endcase
    end

    // Pick which datapath feeds the output registers this cycle
    always_comb begin
        res_lo = alu_res;
        res_hi = '0;
        res_c  = alu_c;
        res_ov = alu_ov;
        if (last_step) begin
            res_lo = lo_nxt;
            res_hi = hi_nxt;
            res_c  = mc_c;
            res_ov = mc_ov;
        end
    end

    // Output registers and flags: update with a done pulse, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            out    <= '0;
            out_hi <= '0;
            P      <= 1'b0;
            Z      <= 1'b0;
            S      <= 1'b0;
            C      <= 1'b0;
            OV     <= 1'b0;
        end else begin
            vld_p1 <= fire_single | last_step;
            if (fire_single | last_step) begin
                out    <= res_lo;
                out_hi <= res_hi;
                P      <= parity_even(res_lo);
                Z      <= (res_lo == '0);
                S      <= res_lo[DATA_W-1];
                C      <= res_c;
                OV     <= res_ov;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc at DATA_W=8, plus a DATA_W=16 overflow case.
module tb_alu_mc;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_ADDC = 4'h8;
    localparam logic [3:0] OP_SUBC = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_DIV  = 4'hD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, ready, c_in, done;
    logic [3:0] alu_op;
    logic [7:0] a, b, out, out_hi;
    logic       P, Z, S, C, OV;
    logic [4:0] flg;
    assign flg = {P, Z, S, C, OV};

    logic        start16, ready16, c_in16, done16;
    logic [3:0]  alu_op16;
    logic [15:0] a16, b16, out16, out_hi16;
    logic        P16, Z16, S16, C16, OV16;

    alu_mc #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .alu_op(alu_op),
        .a(a), .b(b), .c_in(c_in), .out(out), .out_hi(out_hi), .done(done),
        .P(P), .Z(Z), .S(S), .C(C), .OV(OV)
    );

    alu_mc #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .ready(ready16), .alu_op(alu_op16),
        .a(a16), .b(b16), .c_in(c_in16), .out(out16), .out_hi(out_hi16), .done(done16),
        .P(P16), .Z(Z16), .S(S16), .C(C16), .OV(OV16)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                         input logic ci);
        start  = 1'b1;
        alu_op = op;
        a      = va;
        b      = vb;
        c_in   = ci;
    endtask

    // Launch a MUL/DIV and wait (bounded) for done. lat counts edges from the
    // accepting edge inclusive; nbusy counts samples with ready low. If poke is
    // set, an ADD start is pulsed and operands scrambled while the op runs.
    task automatic run_mc(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                          input logic poke, output int lat, output int nbusy);
        drive(op, va, vb, 1'b0);
        step();
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (!ready) nbusy++;
            if (poke && lat == 2) drive(OP_ADD, 8'h01, 8'h01, 1'b1);
            else begin
                start = 1'b0;
                a     = 8'h33;
                b     = 8'h44;
            end
            step();
            lat++;
        end
        start = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] va;
        logic [7:0] vb;
        logic       ci;
        logic [7:0] res;
        logic [4:0] flg;   // {P,Z,S,C,OV}
    } vec_t;

    vec_t vecs [0:14] = '{
        '{OP_LD,   8'h12, 8'h34, 1'b0, 8'h34, 5'b00000},
        '{OP_AND,  8'hF0, 8'h3C, 1'b0, 8'h30, 5'b10000},
        '{OP_OR,   8'hF0, 8'h0F, 1'b0, 8'hFF, 5'b10100},
        '{OP_XOR,  8'hAA, 8'hAA, 1'b0, 8'h00, 5'b11000},
        '{OP_INC,  8'h7F, 8'h55, 1'b1, 8'h80, 5'b00101},
        '{OP_INC,  8'hFF, 8'h55, 1'b0, 8'h00, 5'b11010},
        '{OP_NOT,  8'h0F, 8'h00, 1'b0, 8'hF0, 5'b10100},
        '{OP_SUB,  8'h80, 8'h01, 1'b0, 8'h7F, 5'b00001},
        '{OP_SUBC, 8'h05, 8'h05, 1'b1, 8'hFF, 5'b10110},
        '{OP_SHL,  8'h81, 8'h00, 1'b0, 8'h02, 5'b00010},
        '{OP_ADD,  8'hFF, 8'h01, 1'b0, 8'h00, 5'b11010},
        '{4'hE,    8'hFF, 8'hFF, 1'b1, 8'h00, 5'b11000},
        '{4'hF,    8'h12, 8'h34, 1'b0, 8'h00, 5'b11000},
        '{OP_ADDC, 8'h7F, 8'h00, 1'b1, 8'h80, 5'b00101},
        '{OP_SHR,  8'h81, 8'h00, 1'b0, 8'h40, 5'b00010}
    };

    initial begin
        int lat;
        int nbusy;
        int ndone;

        rst = 1'b1;
        start = 1'b0; alu_op = 4'h0; a = 8'h00; b = 8'h00; c_in = 1'b0;
        start16 = 1'b0; alu_op16 = 4'h0; a16 = 16'h0; b16 = 16'h0; c_in16 = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_out",    out,    8'h00);
        check("rst_out_hi", out_hi, 8'h00);
        check("rst_done",   done,   1'b0);
        check("rst_ready",  ready,  1'b1);
        check("rst_flg",    flg,    5'b00000);
        rst = 1'b0;

        // Signed overflow on ADD, both widths
        drive(OP_ADD, 8'h7F, 8'h01, 1'b0);
        start16 = 1'b1; alu_op16 = OP_ADD; a16 = 16'h7FFF; b16 = 16'h0001;
        step();
        start = 1'b0; start16 = 1'b0;
        check("add_out",  out,  8'h80);
        check("add_flg",  flg,  5'b00101);
        check("add_done", done, 1'b1);
        check("add16_out",  out16,  16'h8000);
        check("add16_S",    S16,    1'b1);
        check("add16_OV",   OV16,   1'b1);
        check("add16_done", done16, 1'b1);
        step();
        check("add_done_clr", done, 1'b0);
        check("add_hold",     out,  8'h80);

        // SUB borrow then back-to-back ADDC
        drive(OP_SUB, 8'h00, 8'h01, 1'b0);
        step();
        check("sub_out",  out,  8'hFF);
        check("sub_flg",  flg,  5'b10110);
        check("sub_done", done, 1'b1);
        drive(OP_ADDC, 8'hFF, 8'h00, 1'b1);
        step();
        start = 1'b0;
        check("addc_out",  out,  8'h00);
        check("addc_flg",  flg,  5'b11010);
        check("addc_done", done, 1'b1);

        // MUL with an ignored ADD start and operand changes while running
        run_mc(OP_MUL, 8'hFF, 8'hFF, 1'b1, lat, nbusy);
        check("mul_lat",    lat,    9);
        check("mul_busy",   nbusy,  8);
        check("mul_out",    out,    8'h01);
        check("mul_out_hi", out_hi, 8'hFE);
        check("mul_flg",    flg,    5'b00011);
        step();
        check("mul_done_clr", done,   1'b0);
        check("mul_ready",    ready,  1'b1);
        check("mul_hold_hi",  out_hi, 8'hFE);

        // DIV normal and divide-by-zero
        run_mc(OP_DIV, 8'd200, 8'd7, 1'b0, lat, nbusy);
        check("div_lat",    lat,    9);
        check("div_out",    out,    8'h1C);
        check("div_out_hi", out_hi, 8'h04);
        check("div_flg",    flg,    5'b00000);
        run_mc(OP_DIV, 8'h55, 8'h00, 1'b0, lat, nbusy);
        check("div0_lat",    lat,    9);
        check("div0_out",    out,    8'hFF);
        check("div0_out_hi", out_hi, 8'h55);
        check("div0_flg",    flg,    5'b10101);

        // Outputs hold while inputs change without start
        a = 8'h01; b = 8'h02; alu_op = OP_ADD;
        step();
        step();
        check("hold_out",  out,  8'hFF);
        check("hold_flg",  flg,  5'b10101);
        check("hold_done", done, 1'b0);

        // Single-cycle vector table
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].ci);
            step();
            start = 1'b0;
            check($sformatf("v%0d_out", i),    out,    vecs[i].res);
            check($sformatf("v%0d_out_hi", i), out_hi, 8'h00);
            check($sformatf("v%0d_flg", i),    flg,    vecs[i].flg);
            check($sformatf("v%0d_done", i),   done,   1'b1);
        end

        // Reset four cycles into a MUL aborts it
        drive(OP_MUL, 8'h10, 8'h10, 1'b0);
        step();
        start = 1'b0;
        repeat (3) step();
        check("pre_rst_ready", ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_out",    out,    8'h00);
        check("arst_out_hi", out_hi, 8'h00);
        check("arst_done",   done,   1'b0);
        check("arst_ready",  ready,  1'b1);
        check("arst_flg",    flg,    5'b00000);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            step();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        drive(OP_ADD, 8'h03, 8'h04, 1'b0);
        step();
        start = 1'b0;
        check("post_rst_out",  out,  8'h07);
        check("post_rst_done", done, 1'b1);
        check("post_rst_flg",  flg,  5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: DATA_W, default 8, operand/result width in bits; legal range 4..32.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: start  in  1  request to execute; accepted only when ready=1.
REQ-005 Port: ready  out  1  high when idle and able to accept start.
REQ-006 Port: alu_op  in  4  operation code, sampled at accepted start.
REQ-007 Port: a, b  in  DATA_W each  operands, sampled at accepted start.
REQ-008 Port: c_in  in  1  carry/borrow input for ADDC/SUBC, sampled at accepted start.
REQ-009 Port: out  out  DATA_W  result low word / quotient, registered.
REQ-010 Port: out_hi  out  DATA_W  product high word / remainder; 0 for all other ops; registered.
REQ-011 Port: done  out  1  one-cycle pulse when out/out_hi/flags update.
REQ-012 Port: P, Z, S, C, OV  out  1 each  parity(even), zero, sign, carry/borrow, signed overflow; registered.

Function
REQ-013 Opcodes: 0 LD(out=b), 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB(a-b), 6 INC(a+1), 7 NOT(~a), 8 ADDC(a+b+c_in), 9 SUBC(a-b-c_in), A SHL(a<<1), B SHR(a>>1 logical), C MUL(unsigned a*b), D DIV(unsigned a/b), E/F reserved.
REQ-014 FSM states IDLE and RUN; ready=1 exactly in IDLE.
REQ-015 IDLE, start=1, op not C/D: result computed, registered, done=1 on next edge; FSM stays IDLE (latency 1, back-to-back starts allowed every cycle).
REQ-016 IDLE, start=1, op C or D: operands latched, FSM->RUN, iteration counter loaded with DATA_W.
REQ-017 RUN: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; after DATA_W steps FSM->IDLE with done=1 on that edge (latency DATA_W+1 from start edge).
REQ-018 start while ready=0 ignored; a, b, alu_op, c_in changes during RUN have no effect.
REQ-019 out, out_hi, flags hold previous values between done pulses.
REQ-020 Z=(out==0); S=out[DATA_W-1]; P=1 when popcount(out) even; flags use out only, never out_hi.
REQ-021 C: ADD/ADDC/INC carry-out of bit DATA_W-1; SUB/SUBC borrow (1 when a < b(+c_in) unsigned); SHL a[DATA_W-1]; SHR a[0]; MUL (out_hi!=0); all other ops 0.
REQ-022 OV: ADD/ADDC/INC set when operand sign bits equal and result sign differs; SUB/SUBC set when a and b signs differ and result sign differs from a; MUL equals C; DIV set only on divide-by-zero; all other ops 0.
REQ-023 DIV with b=0: out=all ones, out_hi=a, OV=1, C=0, same DATA_W+1 latency.
REQ-024 Reserved opcodes E/F: out=0, out_hi=0, C=0, OV=0, Z=1, P=1, done pulses at latency 1.
REQ-025 All arithmetic modulo 2^DATA_W on out; no sign bit hard-coded to a fixed index.

Reset
REQ-026 rst=1 forces immediately: FSM=IDLE, counter=0, out=0, out_hi=0, done=0, P=Z=S=C=OV=0; ready=1.
REQ-027 rst during RUN aborts operation; no done pulse for the aborted op; first start accepted on first edge after rst deasserts.

Verification (DATA_W=8)
REQ-028 ADD a=0x7F b=0x01 -> next edge: out=0x80, S=1, OV=1, C=0, Z=0, P=0, done one cycle.
REQ-029 SUB a=0x00 b=0x01 -> out=0xFF, C=1, S=1, P=1, OV=0; then ADDC a=0xFF b=0x00 c_in=1 back-to-back -> out=0x00, C=1, Z=1, P=1.
REQ-030 MUL a=0xFF b=0xFF -> ready=0 for 8 cycles, done exactly 9 cycles after start edge, out=0x01, out_hi=0xFE, C=OV=1.
REQ-031 DIV a=200 b=7 -> out=0x1C, out_hi=0x04, OV=0; DIV a=0x55 b=0 -> out=0xFF, out_hi=0x55, OV=1.
REQ-032 start pulsed with ADD during MUL RUN -> ignored, MUL result unaffected; rst asserted 4 cycles into MUL -> all outputs 0, ready=1, no done; new ADD after release completes in 1 cycle.
REQ-033 DATA_W=16 rerun of REQ-028 with a=0x7FFF b=0x0001 -> out=0x8000, S=1, OV=1.
